// File: rtl/lsu_ctrl.sv
// Load/store unit: sequences one core load/store over a req/ack word bus, stalling the core until done.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [2:0]  mode_q, mode_d;
  logic [1:0]  off_q, off_d;

  logic        is_half, is_word, trap;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Mode bit 1 set means word (covers 010, 011, 110, 111).
  assign is_word = mem_acc_mode[1];
  assign is_half = ~mem_acc_mode[1] & mem_acc_mode[0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (rd_en | wr_en) & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign misalign = (state_q == IDLE) & trap;
  assign stall    = ((state_q == IDLE) & (rd_en | wr_en) & ~trap) | (state_q == REQ);

  always_comb begin
    st_data = wdata;
    st_strb = 4'b1111;
    if (is_half) begin
      st_data = {2{wdata[15:0]}};
      st_strb = 4'b0011 << {addr[1], 1'b0};
    end else if (!is_word) begin
      st_data = {4{wdata[7:0]}};
      st_strb = 4'b0001 << addr[1:0];
    end
  end

  // Load lane select uses the offset and mode captured at request time.
  always_comb begin
    ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
    ld_half = bus_rdata[{off_q[1], 4'b0000} +: 16];
    if (mode_q[1]) begin
      ld_val = bus_rdata;
    end else if (mode_q[0]) begin
      ld_val = {{16{ld_half[15] & ~mode_q[2]}}, ld_half};
    end else begin
      ld_val = {{24{ld_byte[7] & ~mode_q[2]}}, ld_byte};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    mode_d      = mode_q;
    off_d       = off_q;
    case (state_q)
      IDLE: begin
        if ((rd_en | wr_en) & ~trap) begin
          state_d     = REQ;
          cnt_d       = 32'd0;
          bus_req_d   = 1'b1;
          bus_we_d    = wr_en;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_wdata_d = st_data;
          bus_wstrb_d = wr_en ? st_strb : 4'b0000;
          mode_d      = mem_acc_mode;
          off_d       = addr[1:0];
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            rdata_d = ld_val;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 32'd0;
      rdata_q     <= 32'd0;
      bus_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wstrb_q <= 4'b0000;
      mode_q      <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      mode_q      <= mode_d;
      off_q       <= off_d;
    end
  end

  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written corner sequences,
// and randomized accesses checked against an arithmetic model of the lane/extension rules.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [2:0]  mem_acc_mode;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, bus_err, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_rdata = 32'd0;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .mem_acc_mode(mem_acc_mode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .bus_err(bus_err),
    .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (act=timeout req=finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: access size in bytes from the mode code.
  function automatic int m_size(input logic [2:0] mode);
    if (mode[1]) return 4;
    if (mode[0]) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] mode, input logic [31:0] wd);
    case (m_size(mode))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] mode, input logic [31:0] a);
    int sh;
    case (m_size(mode))
      1: begin sh = int'(a % 4); return 4'(1 << sh); end
      2: begin sh = int'(a & 2); return 4'(3 << sh); end
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] mode, input logic [31:0] a,
                                          input logic [31:0] w);
    logic [31:0] v;
    case (m_size(mode))
      1: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (!mode[2] && v >= 128) v = v - 32'd256;
      end
      2: begin
        v = (w >> (8 * (a & 2))) & 32'hFFFF;
        if (!mode[2] && v >= 32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One full access starting in IDLE; returns in the IDLE cycle after DONE.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] mode, input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic ack, input logic [31:0] brd,
                            input logic [31:0] exp_rdata, input logic [3:0] exp_wstrb,
                            input logic [31:0] exp_wdata);
    int total;
    rd_en = rd; wr_en = wr; mem_acc_mode = mode; addr = a; wdata = wd;
    #1;
    check({tag, " idle_stall"}, 32'(stall), 32'd1);
    check({tag, " idle_misalign"}, 32'(misalign), 32'd0);
    @(posedge clk); #1;
    check({tag, " bus_req"}, 32'(bus_req), 32'd1);
    check({tag, " bus_we"}, 32'(bus_we), 32'(wr));
    check({tag, " bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
    check({tag, " bus_wstrb"}, 32'(bus_wstrb), wr ? 32'(exp_wstrb) : 32'd0);
    if (wr) check({tag, " bus_wdata"}, bus_wdata, exp_wdata);
    total = ack ? waits + 1 : TO;
    for (int c = 0; c < total; c++) begin
      check({tag, " req_stall"}, 32'(stall), 32'd1);
      check({tag, " req_hold"}, 32'(bus_req), 32'd1);
      bus_ack = ack && (c == waits);
      bus_rdata = brd;
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    if (!ack) last_rdata = 32'd0;
    else if (!wr) last_rdata = exp_rdata;
    check({tag, " done_stall"}, 32'(stall), 32'd0);
    check({tag, " done_req"}, 32'(bus_req), 32'd0);
    check({tag, " done_err"}, 32'(bus_err), 32'(!ack));
    check({tag, " done_rdata"}, rdata, last_rdata);
    rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle_err"}, 32'(bus_err), 32'd0);
    check({tag, " idle_after_stall"}, 32'(stall), 32'd0);
    $display("txn %s rd=%0b wr=%0b mode=%03b addr=%08h waits=%0d ack=%0b rdata=%08h strb=%04b",
             tag, rd, wr, mode, a, waits, ack, rdata, exp_wstrb);
  endtask

  typedef struct {
    string       tag;
    logic        rd, wr;
    logic [2:0]  mode;
    logic [31:0] a, wd;
    int          waits;
    logic        ack;
    logic [31:0] brd, exp_rdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"LW104",   1, 0, 3'b010, 32'h104, 0,            0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 0};
    vecs[1]  = '{"LB203",   1, 0, 3'b000, 32'h203, 0,            0, 1, 32'h80123456, 32'hFFFFFF80, 4'h0, 0};
    vecs[2]  = '{"LBU203",  1, 0, 3'b100, 32'h203, 0,            0, 1, 32'h80123456, 32'h00000080, 4'h0, 0};
    vecs[3]  = '{"SH102",   0, 1, 3'b001, 32'h102, 32'h0000ABCD, 2, 1, 0, 0, 4'b1100, 32'hABCDABCD};
    vecs[4]  = '{"LH002",   1, 0, 3'b001, 32'h002, 0,            1, 1, 32'h80017FFF, 32'hFFFF8001, 4'h0, 0};
    vecs[5]  = '{"LHU000",  1, 0, 3'b101, 32'h000, 0,            0, 1, 32'h8001F00F, 32'h0000F00F, 4'h0, 0};
    vecs[6]  = '{"SB001",   0, 1, 3'b000, 32'h001, 32'h12345678, 0, 1, 0, 0, 4'b0010, 32'h78787878};
    vecs[7]  = '{"SW010",   0, 1, 3'b010, 32'h010, 32'hCAFEBABE, 1, 1, 0, 0, 4'b1111, 32'hCAFEBABE};
    vecs[8]  = '{"RDWR020", 1, 1, 3'b010, 32'h020, 32'h11223344, 0, 1, 0, 0, 4'b1111, 32'h11223344};
    vecs[9]  = '{"M111",    1, 0, 3'b111, 32'h030, 0,            0, 1, 32'hA5A55A5A, 32'hA5A55A5A, 4'h0, 0};
    vecs[10] = '{"ACKLAST", 1, 0, 3'b110, 32'h034, 0,            3, 1, 32'h01020304, 32'h01020304, 4'h0, 0};
    vecs[11] = '{"TIMEOUT", 1, 0, 3'b010, 32'h040, 0,            0, 0, 32'h77777777, 32'h0, 4'h0, 0};

    rst = 1'b0; rd_en = 0; wr_en = 0; mem_acc_mode = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst bus_req", 32'(bus_req), 0);
    check("rst bus_we", 32'(bus_we), 0);
    check("rst bus_addr", bus_addr, 0);
    check("rst bus_wdata", bus_wdata, 0);
    check("rst bus_wstrb", 32'(bus_wstrb), 0);
    check("rst rdata", rdata, 0);
    check("rst bus_err", 32'(bus_err), 0);
    check("rst misalign", 32'(misalign), 0);
    check("rst stall", 32'(stall), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Non-memory instructions: no stall, no bus activity.
    repeat (2) begin
      @(posedge clk); #1;
      check("nomem stall", 32'(stall), 0);
      check("nomem bus_req", 32'(bus_req), 0);
    end

    foreach (vecs[i])
      run_access(vecs[i].tag, vecs[i].rd, vecs[i].wr, vecs[i].mode, vecs[i].a, vecs[i].wd,
                 vecs[i].waits, vecs[i].ack, vecs[i].brd, vecs[i].exp_rdata,
                 vecs[i].exp_wstrb, vecs[i].exp_wdata);

    // Misaligned word load at 0x101.
`ifdef LSU_MISALIGN_TRAP_EN
    run_access("LWPRE", 1, 0, 3'b010, 32'h50, 0, 0, 1, 32'h13579BDF, 32'h13579BDF, 0, 0);
    rd_en = 1; mem_acc_mode = 3'b010; addr = 32'h101;
    #1;
    check("trap misalign", 32'(misalign), 1);
    check("trap stall", 32'(stall), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("trap no_req", 32'(bus_req), 0);
      check("trap rdata_hold", rdata, last_rdata);
      check("trap misalign_hold", 32'(misalign), 1);
    end
    mem_acc_mode = 3'b001; addr = 32'h3;
    #1;
    check("trap half misalign", 32'(misalign), 1);
    check("trap half stall", 32'(stall), 0);
    rd_en = 0;
    #1;
    check("trap clear", 32'(misalign), 0);
    $display("txn TRAP LW addr=00000101 misalign=1");
`else
    run_access("LW101", 1, 0, 3'b010, 32'h101, 0, 0, 1, 32'h55667788, 32'h55667788, 0, 0);
    run_access("LH003", 1, 0, 3'b001, 32'h003, 0, 0, 1, 32'h9ABC1234, 32'hFFFF9ABC, 0, 0);
`endif

    // Reset during the second REQ cycle abandons the access.
    rd_en = 1; mem_acc_mode = 3'b010; addr = 32'h80;
    @(posedge clk); #1;
    check("rstreq first_req", 32'(bus_req), 1);
    @(posedge clk); #1;
    check("rstreq second_req", 32'(bus_req), 1);
    rst = 1'b0; rd_en = 0;
    @(posedge clk); #1;
    check("rstreq bus_req", 32'(bus_req), 0);
    check("rstreq bus_addr", bus_addr, 0);
    check("rstreq bus_we", 32'(bus_we), 0);
    check("rstreq bus_wstrb", 32'(bus_wstrb), 0);
    check("rstreq bus_wdata", bus_wdata, 0);
    check("rstreq rdata", rdata, 0);
    check("rstreq bus_err", 32'(bus_err), 0);
    check("rstreq stall", 32'(stall), 0);
    rst = 1'b1;
    last_rdata = 32'd0;
    $display("txn RESET_IN_REQ done");
    run_access("SB003", 0, 1, 3'b000, 32'h3, 32'h000000AB, 0, 1, 0, 0, 4'b1000, 32'hABABABAB);

    // Randomized accesses against the model.
    for (int k = 0; k < 150; k++) begin
      logic        r, w, ak;
      logic [2:0]  md;
      logic [31:0] a, wd, brd;
      int          wt;
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      md = 3'($urandom_range(0, 7));
      a  = $urandom;
      wd = $urandom;
      brd = $urandom;
      wt = $urandom_range(0, TO - 1);
      ak = ($urandom_range(0, 7) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
      if (m_size(md) == 2) a = a & 32'hFFFF_FFFE;
      if (m_size(md) == 4) a = a & 32'hFFFF_FFFC;
`endif
      if (!r && !w) begin
        rd_en = 0; wr_en = 0; mem_acc_mode = md; addr = a;
        @(posedge clk); #1;
        check("rnd nomem stall", 32'(stall), 0);
        check("rnd nomem req", 32'(bus_req), 0);
      end else begin
        run_access($sformatf("RND%0d", k), r, w, md, a, wd, wt, ak, brd,
                   m_rdata(md, a, brd), m_wstrb(md, a), m_wdata(md, wd));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
